// File: rtl/elevator_scheduler.sv
// elevator_scheduler: single-car SCAN scheduler fed by a button latch.
// Optional feature macro DOOR_REOPEN_EN: a held served button restarts the dwell.
module elevator_scheduler #(
   parameter int BUTTONS_WIDTH = 8,
   parameter int FLOOR_W       = 3,
   parameter int TRAVEL_CYCLES = 16,
   parameter int DOOR_CYCLES   = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
   input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
   input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
   output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
   output logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels,
   output logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels,
   output logic [FLOOR_W-1:0]       current_floor,
   output logic                     direction_up,
   output logic                     moving,
   output logic                     door_open
);

   localparam int BW = BUTTONS_WIDTH;
   localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      MOVING,
      DOOR_OPEN
   } state_t;

   state_t            state;
   logic [TW-1:0]     travel_cnt;
   logic [DW-1:0]     dwell_cnt;

   logic [BW-1:0]      req;
   logic [BW-1:0]      cur_oh;
   logic [BW-1:0]      nxt_oh;
   logic [FLOOR_W-1:0] nxt_floor;
   logic               here;
   logic               above_cur;
   logic               below_cur;
   logic               above_nxt;
   logic               below_nxt;
   logic               in_n;
   logic               up_n;
   logic               dn_n;
   logic               same_n;
   logic               opp_n;
   logic               beyond_n;
   logic               dwell_restart;

   function automatic logic [BW-1:0] onehot(input logic [FLOOR_W-1:0] f);
      return BW'(1) << f;
   endfunction

   function automatic logic any_above(
      input logic [BW-1:0]      r,
      input logic [FLOOR_W-1:0] f
   );
      logic a;
      a = 1'b0;
      for (int i = 0; i < BW; i++)
         if (i > int'(f)) a = a | r[i];
      return a;
   endfunction

   function automatic logic any_below(
      input logic [BW-1:0]      r,
      input logic [FLOOR_W-1:0] f
   );
      logic b;
      b = 1'b0;
      for (int i = 0; i < BW; i++)
         if (i < int'(f)) b = b | r[i];
      return b;
   endfunction

   assign req = active_in_levels
              | active_out_up_levels
              | active_out_down_levels;

   assign nxt_floor = direction_up ? current_floor + FLOOR_W'(1)
                                   : current_floor - FLOOR_W'(1);

   assign cur_oh = onehot(current_floor);
   assign nxt_oh = onehot(nxt_floor);

   assign here      = |(req & cur_oh);
   assign above_cur = any_above(req, current_floor);
   assign below_cur = any_below(req, current_floor);
   assign above_nxt = any_above(req, nxt_floor);
   assign below_nxt = any_below(req, nxt_floor);

   // Request view at the floor the car is about to reach.
   assign in_n     = |(active_in_levels & nxt_oh);
   assign up_n     = |(active_out_up_levels & nxt_oh);
   assign dn_n     = |(active_out_down_levels & nxt_oh);
   assign same_n   = direction_up ? up_n : dn_n;
   assign opp_n    = direction_up ? dn_n : up_n;
   assign beyond_n = direction_up ? above_nxt : below_nxt;

`ifdef DOOR_REOPEN_EN
   assign dwell_restart =
      |((active_in_levels       & inactivate_in_levels) |
        (active_out_up_levels   & inactivate_out_up_levels) |
        (active_out_down_levels & inactivate_out_down_levels));
`else
   assign dwell_restart = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state                      <= IDLE;
         travel_cnt                 <= '0;
         dwell_cnt                  <= '0;
         current_floor              <= '0;
         direction_up               <= 1'b1;
         moving                     <= 1'b0;
         door_open                  <= 1'b0;
         inactivate_in_levels       <= '0;
         inactivate_out_up_levels   <= '0;
         inactivate_out_down_levels <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               travel_cnt <= '0;
               dwell_cnt  <= '0;
               if (here) begin
                  state                      <= DOOR_OPEN;
                  door_open                  <= 1'b1;
                  inactivate_in_levels       <= active_in_levels & cur_oh;
                  inactivate_out_up_levels   <= active_out_up_levels & cur_oh;
                  inactivate_out_down_levels <= active_out_down_levels & cur_oh;
               end else if (above_cur && below_cur) begin
                  state  <= MOVING;
                  moving <= 1'b1;
               end else if (above_cur) begin
                  state        <= MOVING;
                  moving       <= 1'b1;
                  direction_up <= 1'b1;
               end else if (below_cur) begin
                  state        <= MOVING;
                  moving       <= 1'b1;
                  direction_up <= 1'b0;
               end
            end

            MOVING: begin
               if (travel_cnt == T_LAST) begin
                  travel_cnt    <= '0;
                  current_floor <= nxt_floor;
                  // End of sweep: take every call here and turn if asked.
                  if (!beyond_n) begin
                     state                      <= DOOR_OPEN;
                     moving                     <= 1'b0;
                     door_open                  <= 1'b1;
                     dwell_cnt                  <= '0;
                     inactivate_in_levels       <= active_in_levels & nxt_oh;
                     inactivate_out_up_levels   <= active_out_up_levels & nxt_oh;
                     inactivate_out_down_levels <= active_out_down_levels & nxt_oh;
                     if (opp_n) direction_up <= ~direction_up;
                  end else if (in_n || same_n) begin
                     state                <= DOOR_OPEN;
                     moving               <= 1'b0;
                     door_open            <= 1'b1;
                     dwell_cnt            <= '0;
                     inactivate_in_levels <= active_in_levels & nxt_oh;
                     inactivate_out_up_levels <= direction_up ?
                        (active_out_up_levels & nxt_oh) : '0;
                     inactivate_out_down_levels <= direction_up ?
                        '0 : (active_out_down_levels & nxt_oh);
                  end
               end else begin
                  travel_cnt <= travel_cnt + TW'(1);
               end
            end

            DOOR_OPEN: begin
               if (dwell_restart) begin
                  dwell_cnt <= '0;
               end else if (dwell_cnt == D_LAST) begin
                  state                      <= IDLE;
                  dwell_cnt                  <= '0;
                  door_open                  <= 1'b0;
                  inactivate_in_levels       <= '0;
                  inactivate_out_up_levels   <= '0;
                  inactivate_out_down_levels <= '0;
               end else begin
                  dwell_cnt <= dwell_cnt + DW'(1);
               end
            end

            default: begin
               state     <= IDLE;
               moving    <= 1'b0;
               door_open <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed scoreboard bench with a button-latch model.
// Expected stops are queued at stimulus time and popped at each door opening.
module tb_elevator_scheduler;

   localparam int T = 4;
   localparam int D = 6;

   logic       clk;
   logic       reset;
   logic [7:0] lat_in, lat_up, lat_dn;
   logic [7:0] p_in, p_up, p_dn;
   logic [7:0] inact_in, inact_up, inact_dn;
   logic [2:0] current_floor;
   logic       direction_up;
   logic       moving;
   logic       door_open;

   int cyc;
   int t_mark;
   int n_chk;
   int n_pass;

   typedef struct {
      int         id;
      int         lat;
      logic [2:0] flr;
      logic       dir;
      logic [7:0] vi;
      logic [7:0] vu;
      logic [7:0] vd;
      int         dwell;
   } exp_t;

   exp_t sb[$];

   elevator_scheduler #(
      .BUTTONS_WIDTH(8),
      .FLOOR_W(3),
      .TRAVEL_CYCLES(T),
      .DOOR_CYCLES(D)
   ) dut (
      .clk(clk),
      .reset(reset),
      .active_in_levels(lat_in),
      .active_out_up_levels(lat_up),
      .active_out_down_levels(lat_dn),
      .inactivate_in_levels(inact_in),
      .inactivate_out_up_levels(inact_up),
      .inactivate_out_down_levels(inact_dn),
      .current_floor(current_floor),
      .direction_up(direction_up),
      .moving(moving),
      .door_open(door_open)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Button latch: a held press beats a clear request.
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_in <= '0;
         lat_up <= '0;
         lat_dn <= '0;
      end else begin
         lat_in <= (lat_in | p_in) & ~(inact_in & ~p_in);
         lat_up <= (lat_up | p_up) & ~(inact_up & ~p_up);
         lat_dn <= (lat_dn | p_dn) & ~(inact_dn & ~p_dn);
      end
   end

   always_ff @(posedge clk) cyc <= cyc + 1;

   task automatic check(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] expv
   );
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic press(input logic [7:0] i, input logic [7:0] u, input logic [7:0] d);
      p_in   = i;
      p_up   = u;
      p_dn   = d;
      t_mark = cyc;
      @(negedge clk);
      p_in = '0;
      p_up = '0;
      p_dn = '0;
   endtask

   task automatic expect_stop(
      input int         id,
      input int         lat,
      input logic [2:0] flr,
      input logic       dir,
      input logic [7:0] vi,
      input logic [7:0] vu,
      input logic [7:0] vd,
      input int         dwell
   );
      exp_t e;
      e.id = id; e.lat = lat; e.flr = flr; e.dir = dir;
      e.vi = vi; e.vu = vu; e.vd = vd; e.dwell = dwell;
      sb.push_back(e);
   endtask

   task automatic serve_stop();
      exp_t e;
      int   n;
      int   d;
      e = sb.pop_front();
      n = 0;
      while (door_open !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("stop%0d_open", e.id), 32'(door_open), 32'd1);
      check($sformatf("stop%0d_latency", e.id), 32'(cyc - t_mark), 32'(e.lat));
      check($sformatf("stop%0d_floor", e.id), 32'(current_floor), 32'(e.flr));
      check($sformatf("stop%0d_dir", e.id), 32'(direction_up), 32'(e.dir));
      check($sformatf("stop%0d_moving", e.id), 32'(moving), 32'd0);
      check($sformatf("stop%0d_inact", e.id),
            32'({inact_in, inact_up, inact_dn}), 32'({e.vi, e.vu, e.vd}));
      if (e.dwell > 0) begin
         d = 0;
         while (door_open === 1'b1 && d < 200) begin
            d++;
            @(negedge clk);
         end
         check($sformatf("stop%0d_dwell", e.id), 32'(d), 32'(e.dwell));
         check($sformatf("stop%0d_clear", e.id),
               32'({inact_in, inact_up, inact_dn}), 32'd0);
         t_mark = cyc;
      end
   endtask

   initial begin
      int d;
      int exp_hold;
      reset  = 1'b1;
      p_in   = '0;
      p_up   = '0;
      p_dn   = '0;
      cyc    = 0;
      t_mark = 0;
      n_chk  = 0;
      n_pass = 0;

      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_floor", 32'(current_floor), 32'd0);
      check("rst_dir", 32'(direction_up), 32'd1);
      check("rst_moving", 32'(moving), 32'd0);
      check("rst_door", 32'(door_open), 32'd0);
      check("rst_inact", 32'({inact_in, inact_up, inact_dn}), 32'd0);
      repeat (3) @(negedge clk);
      check("idle_moving", 32'(moving), 32'd0);
      check("idle_door", 32'(door_open), 32'd0);

      // cabin call at the current floor
      expect_stop(2, 2, 3'd0, 1'b1, 8'h01, 8'h00, 8'h00, D);
      press(8'h01, 8'h00, 8'h00);
      serve_stop();
      check("t2_latch_cleared", 32'(lat_in), 32'd0);

      // three-floor trip up
      expect_stop(3, 2 + 3 * T, 3'd3, 1'b1, 8'h08, 8'h00, 8'h00, D);
      press(8'h08, 8'h00, 8'h00);
      @(negedge clk);
      check("t3_depart_moving", 32'(moving), 32'd1);
      check("t3_depart_floor", 32'(current_floor), 32'd0);
      repeat (T) @(negedge clk);
      check("t3_floor1", 32'(current_floor), 32'd1);
      repeat (T) @(negedge clk);
      check("t3_floor2", 32'(current_floor), 32'd2);
      serve_stop();

      // back down to floor 0
      expect_stop(30, 2 + 3 * T, 3'd0, 1'b0, 8'h01, 8'h00, 8'h00, D);
      press(8'h01, 8'h00, 8'h00);
      serve_stop();

      // pass down[2] going up, stop at up[5], then serve down[2]
      expect_stop(4, 2 + 5 * T, 3'd5, 1'b1, 8'h00, 8'h20, 8'h00, D);
      expect_stop(41, 1 + 3 * T, 3'd2, 1'b0, 8'h00, 8'h00, 8'h04, D);
      press(8'h00, 8'h20, 8'h04);
      serve_stop();
      serve_stop();

      // reset in the middle of travel from floor 2 to 3
      press(8'h40, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      check("t5_pre_moving", 32'(moving), 32'd1);
      check("t5_pre_floor", 32'(current_floor), 32'd2);
      check("t5_pre_dir", 32'(direction_up), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_floor", 32'(current_floor), 32'd0);
      check("t5_moving", 32'(moving), 32'd0);
      check("t5_door", 32'(door_open), 32'd0);
      check("t5_dir", 32'(direction_up), 32'd1);
      check("t5_inact", 32'({inact_in, inact_up, inact_dn}), 32'd0);
      repeat (2) @(negedge clk);
      check("t5_stays_idle", 32'(moving), 32'd0);

      // end of up sweep with only down[4]: serve it and turn around
      expect_stop(7, 2 + 4 * T, 3'd4, 1'b0, 8'h00, 8'h00, 8'h10, D);
      press(8'h00, 8'h00, 8'h10);
      serve_stop();

      // several calls at the current floor served together
      expect_stop(8, 2, 3'd4, 1'b0, 8'h10, 8'h10, 8'h00, D);
      press(8'h10, 8'h10, 8'h00);
      serve_stop();

      // cabin button held for part of the dwell
`ifdef DOOR_REOPEN_EN
      exp_hold = 4 + D;
`else
      exp_hold = D;
`endif
      expect_stop(6, 2, 3'd4, 1'b0, 8'h10, 8'h00, 8'h00, 0);
      p_in   = 8'h10;
      t_mark = cyc;
      serve_stop();
      d = 0;
      while (door_open === 1'b1 && d < 200) begin
         d++;
         if (d == 4) p_in = '0;
         @(negedge clk);
      end
      p_in = '0;
      check("t6_dwell", 32'(d), 32'(exp_hold));
      check("t6_latch_cleared", 32'(lat_in), 32'd0);
      repeat (3) @(negedge clk);
      check("t6_no_reserve", 32'(door_open), 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
